traffic_light_rr_ctrl: RTL and testbench

//   Timed, parametrised N-direction traffic-light controller. Successor to the two-way NS/EW car-sensor FSM.

---
 rtl/traffic_light_rr_ctrl.sv | 179 +++++++++++++++++
 tb/tb_traffic_light_rr_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_rr_ctrl.sv
// traffic_light_rr_ctrl: timed N-direction traffic-light controller.
// One direction owns green/yellow at a time; others stay red. Waiting
// directions are served round-robin after the current direction's green,
// followed by yellow and an optional all-red clearance. The lamps are a
// registered decode of the next state, so they follow phase/active_dir
// exactly and carry no combinational path from car_req_i.

// Per-direction lamp decode: exactly one of green/yellow/red is set.
module traffic_light_rr_lamp #(
  parameter int IDX   = 0,
  parameter int DIR_W = 2
) (
  input  logic [1:0]       phase_i,
  input  logic [DIR_W-1:0] dir_i,
  output logic             green_o,
  output logic             yellow_o,
  output logic             red_o
);
  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;

  logic own;

  // Only the owning direction can be non-red; an illegal phase shows red.
  always_comb begin
    own      = (dir_i == DIR_W'(IDX));
    green_o  = own && (phase_i == PH_GREEN);
    yellow_o = own && (phase_i == PH_YELLOW);
    red_o    = !(green_o || yellow_o);
  end
endmodule

module traffic_light_rr_ctrl #(
  parameter  int N_DIR     = 4,
  parameter  int CNT_W     = 8,
  parameter  int MIN_GREEN = 8,
  parameter  int MAX_GREEN = 32,
  parameter  int YELLOW_T  = 3,
  parameter  int ALLRED_T  = 1,
  localparam int DIR_W     = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DIR-1:0] car_req_i,
  output logic [N_DIR-1:0] green_o,
  output logic [N_DIR-1:0] yellow_o,
  output logic [N_DIR-1:0] red_o,
  output logic [DIR_W-1:0] active_dir_o,
  output logic [1:0]       phase_o
);
  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  // Last timer value of each phase (timer t = (t+1)-th cycle of the phase).
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1  = (ALLRED_T == 0) ? '0 : CNT_W'(ALLRED_T - 1);

  phase_e             phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [DIR_W-1:0]   next_q, next_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [N_DIR-1:0]   green_q, yellow_q, red_q;
  logic [N_DIR-1:0]   green_d, yellow_d, red_d;

  logic [N_DIR-1:0]   others;
  logic               own_req;
  logic [DIR_W-1:0]   rr_dir;
  int                 idx;
  logic [DIR_W-1:0]   idx_w;

  // Round-robin pick: first waiting direction after the current one,
  // scanning downward so the nearest successor wins.
  always_comb begin
    others  = car_req_i & ~(N_DIR'(1) << dir_q);
    own_req = car_req_i[dir_q];
    rr_dir  = '0;
    idx     = 0;
    idx_w   = '0;
    for (int k = N_DIR - 1; k >= 1; k--) begin
      idx = int'(dir_q) + k;
      if (idx >= N_DIR) idx = idx - N_DIR;
      idx_w = DIR_W'(idx);
      if (others[idx_w]) rr_dir = idx_w;
    end
  end

  // Next-state logic for phase, owner, latched successor and phase timer.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    next_d  = next_q;
    timer_d = timer_q;
    case (phase_q)
      PH_GREEN: begin
        if ((|others) && (((timer_q >= MIN_M1) && !own_req) || (timer_q >= MAX_M1))) begin
          phase_d = PH_YELLOW;
          timer_d = '0;
          next_d  = rr_dir;
        end else if (timer_q < MAX_M1) begin
          // Idle green saturates instead of wrapping.
          timer_d = timer_q + CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (timer_q >= YEL_M1) begin
          timer_d = '0;
          if (ALLRED_T == 0) begin
            phase_d = PH_GREEN;
            dir_d   = next_q;
          end else begin
            phase_d = PH_ALLRED;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      PH_ALLRED: begin
        if ((ALLRED_T == 0) || (timer_q >= AR_M1)) begin
          phase_d = PH_GREEN;
          dir_d   = next_q;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        // Corrupted phase encoding: clear the junction before continuing.
        phase_d = PH_ALLRED;
        timer_d = '0;
      end
    endcase
  end

  // Lamp decode of the next state, one instance per direction.
  for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
    traffic_light_rr_lamp #(
      .IDX   (i),
      .DIR_W (DIR_W)
    ) u_lamp (
      .phase_i  (phase_d),
      .dir_i    (dir_d),
      .green_o  (green_d[i]),
      .yellow_o (yellow_d[i]),
      .red_o    (red_d[i])
    );
  end

  // State and registered lamp outputs; reset forces dir0 green at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_GREEN;
      dir_q    <= '0;
      next_q   <= '0;
      timer_q  <= '0;
      green_q  <= N_DIR'(1);
      yellow_q <= '0;
      red_q    <= ~N_DIR'(1);
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      next_q   <= next_d;
      timer_q  <= timer_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign green_o      = green_q;
  assign yellow_o     = yellow_q;
  assign red_o        = red_q;
  assign active_dir_o = dir_q;
  assign phase_o      = phase_q;
endmodule

// File: tb/tb_traffic_light_rr_ctrl.sv
// Bench for traffic_light_rr_ctrl: a cycle model pushes the expected lamp /
// phase vector per driven cycle; it is popped and compared after each edge.
// A green-run monitor checks service order and green lengths per scenario.
module tb_traffic_light_rr_ctrl;
  localparam int N  = 4;
  localparam int DW = 2;
  localparam int MING = 8;
  localparam int MAXG = 32;
  localparam int YT = 3;
  localparam int AR = 1;
  localparam logic [31:0] RST_V = {16'h0, 4'b0001, 4'b0000, 4'b1110, 2'b00, 2'b00};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  car_req;
  logic [N-1:0]  green, yellow, red;
  logic [DW-1:0] adir;
  logic [1:0]    phase;

  always #5 clk = ~clk;

  traffic_light_rr_ctrl #(
    .N_DIR(N), .CNT_W(8), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW_T(YT), .ALLRED_T(AR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .car_req_i    (car_req),
    .green_o      (green),
    .yellow_o     (yellow),
    .red_o        (red),
    .active_dir_o (adir),
    .phase_o      (phase)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: m_len counts cycles spent in the current phase (1-based).
  int m_ph, m_dir, m_len, m_nxt;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_ph = 0; m_dir = 0; m_len = 1; m_nxt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req);
    logic [N-1:0] oth;
    int pick;
    oth = req;
    oth[m_dir] = 1'b0;
    if (m_ph == 0) begin
      if (oth != 0 && ((m_len >= MING && !req[m_dir]) || m_len >= MAXG)) begin
        pick = -1;
        for (int k = 1; k < N; k++)
          if (pick < 0 && oth[(m_dir + k) % N]) pick = (m_dir + k) % N;
        m_nxt = pick; m_ph = 1; m_len = 1;
      end else m_len++;
    end else if (m_ph == 1) begin
      if (m_len == YT) begin
        m_len = 1;
        if (AR == 0) begin m_ph = 0; m_dir = m_nxt; end
        else m_ph = 2;
      end else m_len++;
    end else begin
      if (m_len == AR) begin m_ph = 0; m_dir = m_nxt; m_len = 1; end
      else m_len++;
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [N-1:0] g, y;
    logic [DW-1:0] d;
    logic [1:0] p;
    g = '0; y = '0;
    if (m_ph == 0) g[m_dir] = 1'b1;
    if (m_ph == 1) y[m_dir] = 1'b1;
    d = m_dir[DW-1:0];
    p = m_ph[1:0];
    return {16'h0, g, y, ~(g | y), d, p};
  endfunction

  // Green-run monitor.
  int g_prev, g_run;
  int g_order[$];
  int g_lens[$];

  task automatic mon_reset();
    g_prev = -1; g_run = 0;
    g_order.delete(); g_lens.delete();
  endtask

  task automatic mon_sample();
    int gd;
    gd = (green != 0) ? int'(adir) : -1;
    if (gd >= 0 && gd == g_prev) g_run++;
    else begin
      if (g_prev >= 0) g_lens.push_back(g_run);
      if (gd >= 0) begin g_order.push_back(gd); g_run = 1; end
      g_prev = gd;
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step(input logic [N-1:0] req);
    car_req = req;
    model_step(req);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    chk("seq", {16'h0, green, yellow, red, adir, phase}, exp_q.pop_front());
    mon_sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    car_req = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset", {16'h0, green, yellow, red, adir, phase}, RST_V);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    mon_reset();
    mon_sample();
  endtask

  initial begin
    rst = 1'b1;
    car_req = '0;

    // 1: idle junction keeps dir0 green.
    do_reset();
    for (int i = 0; i < 100; i++) step(4'b0000);
    chk("idle_runs", g_order.size(), 1);
    chk("idle_green", green, 4'b0001);

    // 2: single request on dir2 after minimum green.
    do_reset();
    for (int i = 0; i < 20; i++) step(4'b0100);
    chk("t2_len0", q_at(g_lens, 0), MING);
    chk("t2_dir1", q_at(g_order, 1), 2);
    chk("t2_adir", adir, 2);

    // 3: own request held extends green to max.
    do_reset();
    for (int i = 0; i < 80; i++) step(4'b0011);
    chk("t3_len0", q_at(g_lens, 0), MAXG);
    chk("t3_len1", q_at(g_lens, 1), MAXG);
    chk("t3_ord1", q_at(g_order, 1), 1);
    chk("t3_ord2", q_at(g_order, 2), 0);

    // 4: all busy -> rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 150; i++) step(4'b1111);
    for (int i = 0; i < 5; i++) chk("t4_order", q_at(g_order, i), i % N);
    for (int i = 0; i < 4; i++) chk("t4_len", q_at(g_lens, i), MAXG);

    // 5: request withdrawn during yellow is still served.
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b1000);
    chk("t5_yellow", yellow, 4'b0001);
    for (int i = 0; i < 40; i++) step(4'b0000);
    chk("t5_ord1", q_at(g_order, 1), 3);
    chk("t5_green", green, 4'b1000);

    // 6: async reset mid-yellow, then the sequence restarts from dir0.
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b0100);
    chk("t6_pre", phase, 2'b01);
    #2 rst = 1'b1;
    #1 chk("t6_arst", {16'h0, green, yellow, red, adir, phase}, RST_V);
    #2 rst = 1'b0;
    exp_q.delete();
    model_reset();
    mon_reset();
    mon_sample();
    for (int i = 0; i < 20; i++) step(4'b0100);
    chk("t6_len0", q_at(g_lens, 0), MING);
    chk("t6_dir1", q_at(g_order, 1), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
